// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the architectural PC, issues req/ack fetches to
// a variable-latency instruction memory and presents one instruction to IF/ID.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] PC_LO     = 32'h0000_3000,
    parameter logic [31:0] PC_HI     = 32'h0000_6FFC,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic [31:0] npc_i,
    input  logic        exc_req_i,
    input  logic        eret_req_i,
    input  logic [31:0] epc_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic        adel_o,
    output logic        fetch_busy_o,
    output logic        imem_timeout_o
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    localparam int unsigned CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          if_valid_q, if_valid_d;
    logic [31:0]   if_instr_q, if_instr_d;
    logic [31:0]   if_pc_q, if_pc_d;
    logic          adel_q, adel_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;

    logic          redir;
    logic [31:0]   target;
    logic          addr_legal;
    logic          req;

    always_comb begin
        redir      = exc_req_i | eret_req_i;
        target     = exc_req_i ? EXC_ENTRY : epc_i;
        addr_legal = (addr_q[1:0] == 2'b00) && (addr_q >= PC_LO) && (addr_q <= PC_HI);
        // Request is gated by reset so it stays low while reset is held.
        req        = !reset && (((state_q == S_FETCH) && addr_legal) || (state_q == S_DRAIN));
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        adel_d     = adel_q;

        case (state_q)
            S_FETCH: begin
                if (!addr_legal) begin
                    state_d    = S_VALID;
                    if_valid_d = 1'b1;
                    if_instr_d = '0;
                    if_pc_d    = pc_q;
                    adel_d     = 1'b1;
                end else if (redir && imem_ack_i) begin
                    pc_d   = target;
                    addr_d = target;
                end else if (redir) begin
                    // The outstanding request must complete before the new address is issued.
                    pc_d    = target;
                    state_d = S_DRAIN;
                end else if (imem_ack_i) begin
                    state_d    = S_VALID;
                    if_valid_d = 1'b1;
                    if_instr_d = imem_rdata_i;
                    if_pc_d    = addr_q;
                    adel_d     = 1'b0;
                end
            end
            S_DRAIN: begin
                if (redir) begin
                    pc_d = target;
                end
                if (imem_ack_i) begin
                    addr_d  = redir ? target : pc_q;
                    state_d = S_FETCH;
                end
            end
            S_VALID: begin
                if (redir) begin
                    pc_d       = target;
                    addr_d     = target;
                    state_d    = S_FETCH;
                    if_valid_d = 1'b0;
                end else if (!stall_i) begin
                    pc_d       = npc_i;
                    addr_d     = npc_i;
                    state_d    = S_FETCH;
                    if_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = S_FETCH;
                if_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (imem_ack_i) begin
            wait_cnt_d = '0;
        end else if (req && (wait_cnt_q < TMO)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (wait_cnt_d == TMO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            adel_q     <= 1'b0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            adel_q     <= adel_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign pc_o           = pc_q;
    assign imem_req_o     = req;
    assign imem_addr_o    = addr_q;
    assign if_valid_o     = if_valid_q;
    assign if_instr_o     = if_instr_q;
    assign if_pc_o        = if_pc_q;
    assign adel_o         = adel_q;
    assign fetch_busy_o   = (state_q != S_VALID);
    assign imem_timeout_o = timeout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic [31:0] npc_i;
    logic        exc_req_i;
    logic        eret_req_i;
    logic [31:0] epc_i;
    logic [31:0] pc_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        adel_o;
    logic        fetch_busy_o;
    logic        imem_timeout_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    fetch_sequencer #(
        .RESET_PC  (32'h0000_3000),
        .EXC_ENTRY (32'h0000_4180),
        .PC_LO     (32'h0000_3000),
        .PC_HI     (32'h0000_6FFC),
        .TIMEOUT   (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_i        (stall_i),
        .npc_i          (npc_i),
        .exc_req_i      (exc_req_i),
        .eret_req_i     (eret_req_i),
        .epc_i          (epc_i),
        .pc_o           (pc_o),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_rdata_i   (imem_rdata_i),
        .if_valid_o     (if_valid_o),
        .if_instr_o     (if_instr_o),
        .if_pc_o        (if_pc_o),
        .adel_o         (adel_o),
        .fetch_busy_o   (fetch_busy_o),
        .imem_timeout_o (imem_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall_i      = 1'b0;
        npc_i        = '0;
        exc_req_i    = 1'b0;
        eret_req_i   = 1'b0;
        epc_i        = '0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b1;
        idle_inputs();
        step();

        // Reset values while reset is held
        check("rst_pc", pc_o, 32'h3000);
        check("rst_addr", imem_addr_o, 32'h3000);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_busy", 32'(fetch_busy_o), 32'd1);
        check("rst_valid", 32'(if_valid_o), 32'd0);
        check("rst_instr", if_instr_o, 32'd0);
        check("rst_tmo", 32'(imem_timeout_o), 32'd0);
        reset = 1'b0;
        #1;
        check("req_after_rst", 32'(imem_req_o), 32'd1);
        @(negedge clk);

        // Back-to-back fetch, ack every cycle
        for (int i = 0; i < 3; i++) begin
            a = 32'h3000 + 32'(4 * i);
            check("seq_req", 32'(imem_req_o), 32'd1);
            check("seq_addr", imem_addr_o, a);
            imem_ack_i   = 1'b1;
            imem_rdata_i = a ^ 32'hFFFF_FFFF;
            step();
            check("seq_valid", 32'(if_valid_o), 32'd1);
            check("seq_pc", if_pc_o, a);
            check("seq_instr", if_instr_o, a ^ 32'hFFFF_FFFF);
            check("seq_vreq", 32'(imem_req_o), 32'd0);
            imem_rdata_i = 32'h5555_5555;
            npc_i        = a + 32'd4;
            step();
            check("seq_busy", 32'(fetch_busy_o), 32'd1);
        end
        check("seq_next_addr", imem_addr_o, 32'h300C);

        // Stall hold at 0x3004
        do_reset();
        imem_ack_i = 1'b1; imem_rdata_i = 32'hFFFF_CFFF;
        step();
        npc_i = 32'h3004;
        step();
        imem_rdata_i = 32'hFFFF_CFFB;
        step();
        check("stl_entry_pc", if_pc_o, 32'h3004);
        for (int k = 0; k < 5; k++) begin
            stall_i = 1'b1;
            npc_i   = 32'hBAD0_0000;
            step();
            check("stl_valid", 32'(if_valid_o), 32'd1);
            check("stl_instr", if_instr_o, 32'hFFFF_CFFB);
            check("stl_pc", pc_o, 32'h3004);
        end
        stall_i = 1'b0;
        npc_i   = 32'h3020;
        imem_ack_i = 1'b0;
        step();
        check("stl_rel_addr", imem_addr_o, 32'h3020);
        check("stl_rel_valid", 32'(if_valid_o), 32'd0);
        check("stl_rel_hold", if_instr_o, 32'hFFFF_CFFB);

        // Exception while waiting at 0x3008, ack three cycles later
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0020;
        step();
        imem_ack_i = 1'b0; npc_i = 32'h3008;
        step();
        check("exc_wait_addr", imem_addr_o, 32'h3008);
        exc_req_i = 1'b1;
        step();
        exc_req_i = 1'b0;
        check("drn_pc", pc_o, 32'h4180);
        check("drn_addr", imem_addr_o, 32'h3008);
        check("drn_req", 32'(imem_req_o), 32'd1);
        step();
        step();
        check("drn_valid", 32'(if_valid_o), 32'd0);
        imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        step();
        imem_ack_i = 1'b0;
        check("drn_done_valid", 32'(if_valid_o), 32'd0);
        check("drn_done_addr", imem_addr_o, 32'h4180);
        check("drn_done_instr", if_instr_o, 32'h0000_0020);

        // exc and eret together, then eret alone
        imem_ack_i = 1'b1; imem_rdata_i = 32'h1234_5678;
        step();
        check("h_pc", if_pc_o, 32'h4180);
        check("h_instr", if_instr_o, 32'h1234_5678);
        imem_ack_i = 1'b0;
        exc_req_i = 1'b1; eret_req_i = 1'b1; epc_i = 32'h3100; stall_i = 1'b1;
        step();
        exc_req_i = 1'b0; eret_req_i = 1'b0; stall_i = 1'b0;
        check("prio_addr", imem_addr_o, 32'h4180);
        imem_ack_i = 1'b1;
        step();
        imem_ack_i = 1'b0;
        eret_req_i = 1'b1;
        step();
        eret_req_i = 1'b0;
        check("eret_addr", imem_addr_o, 32'h3100);

        // Redirect and ack in the same fetch cycle
        exc_req_i = 1'b1; imem_ack_i = 1'b1; imem_rdata_i = 32'hCAFE_0000;
        step();
        exc_req_i = 1'b0;
        check("ra_addr", imem_addr_o, 32'h4180);
        check("ra_valid", 32'(if_valid_o), 32'd0);
        step();
        imem_ack_i = 1'b0;
        check("ra_pc", if_pc_o, 32'h4180);

        // Misaligned eret target
        eret_req_i = 1'b1; epc_i = 32'h3002;
        step();
        eret_req_i = 1'b0;
        check("mis_req", 32'(imem_req_o), 32'd0);
        step();
        check("mis_valid", 32'(if_valid_o), 32'd1);
        check("mis_adel", 32'(adel_o), 32'd1);
        check("mis_instr", if_instr_o, 32'd0);
        check("mis_pc", if_pc_o, 32'h3002);

        // Upper bound legal, one past it illegal
        eret_req_i = 1'b1; epc_i = 32'h6FFC;
        step();
        eret_req_i = 1'b0;
        check("hi_req", 32'(imem_req_o), 32'd1);
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0BAD_F00D;
        step();
        imem_ack_i = 1'b0;
        check("hi_adel", 32'(adel_o), 32'd0);
        check("hi_instr", if_instr_o, 32'h0BAD_F00D);
        eret_req_i = 1'b1; epc_i = 32'h7000;
        step();
        eret_req_i = 1'b0;
        check("ovr_req", 32'(imem_req_o), 32'd0);
        step();
        check("ovr_adel", 32'(adel_o), 32'd1);
        check("ovr_pc", if_pc_o, 32'h7000);

        // Watchdog: no ack after request asserts at 0x4180
        exc_req_i = 1'b1;
        step();
        exc_req_i = 1'b0;
        check("wd_req", 32'(imem_req_o), 32'd1);
        for (int c = 0; c < 15; c++) step();
        check("wd_before", 32'(imem_timeout_o), 32'd0);
        step();
        check("wd_at", 32'(imem_timeout_o), 32'd1);
        step();
        step();
        check("wd_sticky", 32'(imem_timeout_o), 32'd1);
        check("wd_pc", pc_o, 32'h4180);

        // Asynchronous reset mid-wait
        reset = 1'b1;
        #1;
        check("arst_pc", pc_o, 32'h3000);
        check("arst_addr", imem_addr_o, 32'h3000);
        check("arst_req", 32'(imem_req_o), 32'd0);
        check("arst_tmo", 32'(imem_timeout_o), 32'd0);
        check("arst_busy", 32'(fetch_busy_o), 32'd1);
        check("arst_valid", 32'(if_valid_o), 32'd0);
        check("arst_adel", 32'(adel_o), 32'd0);
        check("arst_ifpc", if_pc_o, 32'd0);
        step();
        reset = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
